// File: rtl/inv_mod_arbiter.sv
// Round-robin front end that shares one invMod engine among NUM_REQ requesters.
// Screens operands, pulses the engine start, and returns ID-tagged results.
module inv_mod_arbiter #(
  parameter int DATA_WIDTH = 192,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_opM,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         eng_opA,
  output logic [DATA_WIDTH-1:0]         eng_opM,
  output logic                          eng_in_valid,
  input  logic                          eng_out_valid,
  input  logic [DATA_WIDTH-1:0]         eng_out_data,
  output logic                          busy,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a request transfers when req_valid[i] && req_ready[i] (only in IDLE);
  // a response transfers when rsp_valid && rsp_ready, payload held stable until then.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   eng_opA_q, eng_opA_d;
  logic [DATA_WIDTH-1:0]   eng_opM_q, eng_opM_d;

  logic                    found;
  logic [ID_WIDTH-1:0]     gnt_idx;
  logic                    grant_en;
  logic [DATA_WIDTH-1:0]   sel_a, sel_m;
  logic                    ops_ok;

  // Search starts one past the last grant and wraps, giving round-robin fairness.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && (i == (int'(last_grant_q) + k) % NUM_REQ) && req_valid[i]) begin
          found   = 1'b1;
          gnt_idx = ID_WIDTH'(i);
        end
      end
    end
  end

  assign grant_en = (state_q == S_IDLE) && rst_n && found;

  always_comb begin
    req_ready = '0;
    sel_a     = '0;
    sel_m     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_WIDTH'(i)) begin
        req_ready[i] = grant_en;
        sel_a        = req_opA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_m        = req_opM[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Engine preconditions: nonzero a, a < M, M odd, M full width.
  assign ops_ok = (sel_a != '0) && (sel_a < sel_m) && sel_m[0] && sel_m[DATA_WIDTH-1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    eng_opA_d    = eng_opA_q;
    eng_opM_d    = eng_opM_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          eng_opA_d    = sel_a;
          eng_opM_d    = sel_m;
          rsp_id_d     = gnt_idx;
          last_grant_d = gnt_idx;
          if (ops_ok) begin
            state_d = S_ISSUE;
          end else begin
            state_d    = S_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_out_valid) begin
          rsp_data_d = eng_out_data;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      eng_opA_q    <= '0;
      eng_opM_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      eng_opA_q    <= eng_opA_d;
      eng_opM_q    <= eng_opM_d;
    end
  end

  assign rsp_valid    = (state_q == S_RESP);
  assign eng_in_valid = (state_q == S_ISSUE);
  assign busy         = (state_q != S_IDLE);
  assign dbg_state    = state_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign eng_opA      = eng_opA_q;
  assign eng_opM      = eng_opM_q;

endmodule
